// File: rtl/core_ctrl.sv
// Multicycle execution controller: fetch/decode/load/calc/write sequencer with
// RAM busy wait states, an internal return-address stack, and HALT/FAULT states.
module core_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 8,
    parameter int IP_WIDTH     = 8,
    parameter int OPCODE_WIDTH = 8,
    parameter int CTRL_BIT     = 6,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [4*BUS_WIDTH-1:0]             line,
    output logic [IP_WIDTH-1:0]                ip,
    output logic                               line_mem_en,
    input  logic [OPCODE_WIDTH-1:0]            opcode,
    output logic [BUS_WIDTH-1:0]               instr_addr,
    output logic                               instr_mem_en,
    input  logic                               ram_busy,
    input  logic [DATA_WIDTH-1:0]              data_rd,
    output logic [DATA_WIDTH-1:0]              data_wr,
    output logic [BUS_WIDTH-1:0]               addr_rd,
    output logic [BUS_WIDTH-1:0]               addr_wr,
    output logic                               ram_rd_en,
    output logic                               ram_wr_en,
    output logic [OPCODE_WIDTH-1:0]            opcode_alu,
    output logic [DATA_WIDTH-1:0]              value1,
    output logic [DATA_WIDTH-1:0]              value2,
    input  logic [DATA_WIDTH-1:0]              result,
    input  logic                               update_ip,
    output logic                               alu_en,
    output logic                               ip_update_en,
    output logic                               halted,
    output logic                               fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    localparam int SP_WIDTH = $clog2(STACK_DEPTH + 1);
    // Stack storage is rounded up to 2**SP_WIDTH so sp indexes it directly.
    localparam int SLOTS    = 1 << SP_WIDTH;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_OPC, S_LOAD1, S_LOAD2,
        S_CALC, S_WRITE, S_NEXT, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [1:0] {K_JMP, K_CALL, K_RET, K_HALT} kind_t;

    state_t               state, state_nxt;
    kind_t                opc_kind, alu_kind;
    logic [BUS_WIDTH-1:0] addr1, addr2;
    logic                 taken;
    logic [IP_WIDTH-1:0]  stack [SLOTS];
    logic [IP_WIDTH-1:0]  ip_inc;
    logic                 opc_skip_alu, alu_ctrl, stack_full, stack_empty;

    assign opc_kind     = kind_t'(opcode[1:0]);
    assign alu_kind     = kind_t'(opcode_alu[1:0]);
    assign opc_skip_alu = opcode[CTRL_BIT] && (opc_kind != K_JMP);
    assign alu_ctrl     = opcode_alu[CTRL_BIT];
    assign stack_full   = (sp == SP_WIDTH'(STACK_DEPTH));
    assign stack_empty  = (sp == '0);
    assign ip_inc       = ip + IP_WIDTH'(1);
    assign halted       = (state == S_HALT);
    assign fault        = (state == S_FAULT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        line_mem_en  = 1'b0;
        instr_mem_en = 1'b0;
        ram_rd_en    = 1'b0;
        ram_wr_en    = 1'b0;
        alu_en       = 1'b0;
        ip_update_en = 1'b0;
        case (state)
            S_FETCH: begin
                // Gated so every output reads 0 while reset is held.
                line_mem_en = rstn;
                state_nxt   = S_DECODE;
            end
            S_DECODE: begin
                instr_mem_en = 1'b1;
                state_nxt    = S_OPC;
            end
            S_OPC:   state_nxt = opc_skip_alu ? S_NEXT : S_LOAD1;
            S_LOAD1: begin
                ram_rd_en = 1'b1;
                if (!ram_busy) state_nxt = S_LOAD2;
            end
            S_LOAD2: begin
                ram_rd_en = 1'b1;
                if (!ram_busy) state_nxt = S_CALC;
            end
            S_CALC: begin
                alu_en    = 1'b1;
                state_nxt = alu_ctrl ? S_NEXT : S_WRITE;
            end
            S_WRITE: begin
                ram_wr_en = 1'b1;
                if (!ram_busy) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                ip_update_en = 1'b1;
                state_nxt    = S_FETCH;
                if (alu_ctrl) begin
                    case (alu_kind)
                        K_CALL: if (stack_full)  begin state_nxt = S_FAULT; ip_update_en = 1'b0; end
                        K_RET:  if (stack_empty) begin state_nxt = S_FAULT; ip_update_en = 1'b0; end
                        K_HALT: begin state_nxt = S_HALT; ip_update_en = 1'b0; end
                        default: ;
                    endcase
                end
            end
            S_HALT:  state_nxt = S_HALT;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ip         <= '0;
            instr_addr <= '0;
            addr_wr    <= '0;
            addr1      <= '0;
            addr2      <= '0;
            addr_rd    <= '0;
            opcode_alu <= '0;
            value1     <= '0;
            value2     <= '0;
            data_wr    <= '0;
            taken      <= 1'b0;
            sp         <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) stack[i] <= '0;
        end else begin
            case (state)
                S_DECODE: {instr_addr, addr_wr, addr1, addr2} <= line;
                S_OPC: begin
                    opcode_alu <= opcode;
                    if (!opc_skip_alu) addr_rd <= addr1;
                end
                S_LOAD1: if (!ram_busy) begin
                    value1  <= data_rd;
                    addr_rd <= addr2;
                end
                S_LOAD2: if (!ram_busy) value2 <= data_rd;
                S_CALC: begin
                    data_wr <= result;
                    taken   <= update_ip;
                end
                S_NEXT: begin
                    if (!alu_ctrl) begin
                        ip <= ip_inc;
                    end else begin
                        case (alu_kind)
                            K_JMP: ip <= taken ? addr_wr[IP_WIDTH-1:0] : ip_inc;
                            K_CALL: if (!stack_full) begin
                                stack[sp] <= ip_inc;
                                sp        <= sp + SP_WIDTH'(1);
                                ip        <= addr_wr[IP_WIDTH-1:0];
                            end
                            K_RET: if (!stack_empty) begin
                                ip <= stack[sp - SP_WIDTH'(1)];
                                sp <= sp - SP_WIDTH'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed and random instructions checked
// against an instruction-level reference model with memories, ALU and busy RAM.
module tb_core_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] line;
    logic [7:0]  ip;
    logic        line_mem_en;
    logic [7:0]  opcode;
    logic [7:0]  instr_addr;
    logic        instr_mem_en;
    logic        ram_busy;
    logic [7:0]  data_rd, data_wr, addr_rd, addr_wr;
    logic        ram_rd_en, ram_wr_en;
    logic [7:0]  opcode_alu, value1, value2, result;
    logic        update_ip, alu_en, ip_update_en, halted, fault;
    logic [2:0]  sp;

    core_ctrl #(
        .DATA_WIDTH(8), .BUS_WIDTH(8), .IP_WIDTH(8),
        .OPCODE_WIDTH(8), .CTRL_BIT(6), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .line(line), .ip(ip), .line_mem_en(line_mem_en),
        .opcode(opcode), .instr_addr(instr_addr), .instr_mem_en(instr_mem_en),
        .ram_busy(ram_busy), .data_rd(data_rd), .data_wr(data_wr),
        .addr_rd(addr_rd), .addr_wr(addr_wr), .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en), .opcode_alu(opcode_alu), .value1(value1),
        .value2(value2), .result(result), .update_ip(update_ip), .alu_en(alu_en),
        .ip_update_en(ip_update_en), .halted(halted), .fault(fault), .sp(sp)
    );

    always #5 clk = ~clk;

    logic [31:0] line_mem  [256];
    logic [7:0]  instr_mem [256];
    logic [7:0]  ram       [256];
    logic [7:0]  m_ram     [256];

    function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign line      = line_mem[ip];
    assign opcode    = instr_mem[instr_addr];
    assign data_rd   = ram_busy ? ~ram[addr_rd] : ram[addr_rd];
    assign result    = alu_f(opcode_alu, value1, value2);
    assign update_ip = value1[0];

    // Busy generator: stalls[n] busy cycles for the n-th RAM access of an instruction.
    int unsigned stalls [4] = '{0, 0, 0, 0};
    logic [1:0]  acc_idx = '0;
    int unsigned busy_cnt = 0;
    assign ram_busy = (ram_rd_en || ram_wr_en) && (busy_cnt < stalls[acc_idx]);

    always @(posedge clk) begin
        if (line_mem_en) begin
            acc_idx  <= '0;
            busy_cnt <= 0;
        end else if (ram_rd_en || ram_wr_en) begin
            if (ram_busy) busy_cnt <= busy_cnt + 1;
            else begin
                acc_idx  <= acc_idx + 2'd1;
                busy_cnt <= 0;
            end
        end
    end

    int tot = 0;
    int bad = 0;

    logic [7:0] m_ip;
    logic [7:0] m_stack [$];
    bit         m_halt, m_fault;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ram(input logic [7:0] a, input logic [7:0] v);
        ram[a]   = v;
        m_ram[a] = v;
    endtask

    task automatic model_reset();
        m_ip    = '0;
        m_stack.delete();
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        chk({tag, "_regs"}, {ip, instr_addr, data_wr, addr_rd, addr_wr, opcode_alu, value1, value2}, 64'd0);
        chk({tag, "_flags"}, {line_mem_en, instr_mem_en, ram_rd_en, ram_wr_en, alu_en,
                              ip_update_en, halted, fault, sp}, 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk({tag, "_ip0"}, ip, 64'd0);
        chk({tag, "_fetch"}, line_mem_en, 64'd1);
    endtask

    // Runs one instruction from its FETCH cycle to the next FETCH (or HALT/FAULT).
    task automatic run_one(input logic [31:0] ln, input logic [7:0] op,
                           input int unsigned s1, input int unsigned s2, input int unsigned s3,
                           input string tag);
        logic [7:0]  ia, aw, a1, a2;
        int unsigned exp_cyc, exp_wr, exp_upd, cyc, wr, upd;
        bit          done;
        {ia, aw, a1, a2} = ln;
        line_mem[m_ip] = ln;
        instr_mem[ia]  = op;
        stalls[0] = s1; stalls[1] = s2; stalls[2] = s3;

        exp_wr = 0; exp_upd = 1; exp_cyc = 4;
        if (!op[6]) begin
            m_ram[aw] = alu_f(op, m_ram[a1], m_ram[a2]);
            m_ip      = m_ip + 8'd1;
            exp_cyc   = 8 + s1 + s2 + s3;
            exp_wr    = 1;
        end else begin
            case (op[1:0])
                2'd0: begin
                    m_ip    = m_ram[a1][0] ? aw : m_ip + 8'd1;
                    exp_cyc = 7 + s1 + s2;
                end
                2'd1: begin
                    if (m_stack.size() == DEPTH) begin m_fault = 1'b1; exp_upd = 0; end
                    else begin m_stack.push_back(m_ip + 8'd1); m_ip = aw; end
                end
                2'd2: begin
                    if (m_stack.size() == 0) begin m_fault = 1'b1; exp_upd = 0; end
                    else m_ip = m_stack.pop_back();
                end
                default: begin m_halt = 1'b1; exp_upd = 0; end
            endcase
        end

        chk({tag, "_start"}, line_mem_en, 64'd1);
        cyc = 0; wr = 0; upd = 0; done = 1'b0;
        while (!done) begin
            chk({tag, "_onehot"}, $countones({line_mem_en, instr_mem_en, ram_rd_en, ram_wr_en, alu_en}) <= 1, 64'd1);
            if (ram_wr_en && !ram_busy) begin
                ram[addr_wr] = data_wr;
                wr++;
            end
            if (ip_update_en) upd++;
            @(negedge clk);
            cyc++;
            if (line_mem_en || halted || fault) done = 1'b1;
            else if (cyc > 80) begin
                chk({tag, "_timeout"}, cyc, exp_cyc);
                done = 1'b1;
            end
        end
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_ip"}, ip, m_ip);
        chk({tag, "_sp"}, sp, m_stack.size());
        chk({tag, "_halted"}, halted, m_halt);
        chk({tag, "_fault"}, fault, m_fault);
        chk({tag, "_writes"}, wr, exp_wr);
        chk({tag, "_ipupd"}, upd, exp_upd);
        if (!op[6]) chk({tag, "_ram"}, ram[aw], m_ram[aw]);
    endtask

    task automatic hold_check(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk({tag, "_strobes"}, {line_mem_en, instr_mem_en, ram_rd_en, ram_wr_en, alu_en, ip_update_en}, 64'd0);
            chk({tag, "_state"}, {halted, fault}, {m_halt, m_fault});
            chk({tag, "_ip"}, ip, m_ip);
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] ln;
        int unsigned r, k;
        for (int i = 0; i < 256; i++) begin
            line_mem[i]  = '0;
            instr_mem[i] = '0;
            set_ram(8'(i), 8'($urandom));
        end
        model_reset();
        @(negedge clk);
        do_reset("rst0");

        set_ram(8'h10, 8'd3);
        set_ram(8'h11, 8'd4);
        run_one(32'h01201011, 8'h00, 0, 0, 0, "add");
        chk("add_ram20", ram[8'h20], 64'd7);
        chk("add_ip1", ip, 64'd1);
        run_one(32'h01201011, 8'h00, 2, 0, 3, "add_stall");
        chk("stall_value1", value1, 64'd3);

        set_ram(8'h50, 8'h07);
        run_one(32'h02405051, 8'h40, 0, 0, 0, "jmp_taken");
        chk("jmp_ip40", ip, 64'h40);
        set_ram(8'h52, 8'h06);
        run_one(32'h03405251, 8'h40, 0, 0, 0, "jmp_not");
        chk("jmp_ip41", ip, 64'h41);
        set_ram(8'h53, 8'h01);
        run_one(32'h04055351, 8'h40, 1, 2, 0, "jmp_to5");

        run_one(32'h05300000, 8'h41, 0, 0, 0, "call");
        chk("call_ip", ip, 64'h30);
        chk("call_sp", sp, 64'd1);
        run_one(32'h06000000, 8'h42, 0, 0, 0, "ret");
        chk("ret_ip", ip, 64'd6);
        chk("ret_sp", sp, 64'd0);

        for (int n = 0; n < 60; n++) begin
            ln = $urandom;
            op = 8'($urandom);
            r  = $urandom_range(0, 9);
            if (r == 7 && m_stack.size() < DEPTH)     op = {op[7], 1'b1, op[5:2], 2'b01};
            else if (r == 8 && m_stack.size() > 0)    op = {op[7], 1'b1, op[5:2], 2'b10};
            else if (r == 5 || r == 6 || r == 8)      op = {op[7], 1'b1, op[5:2], 2'b00};
            else                                      op[6] = 1'b0;
            run_one(ln, op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end
        while (m_stack.size() > 0) run_one({8'($urandom), 24'h0}, 8'h42, 0, 0, 0, "drain");

        for (int i = 0; i <= DEPTH; i++)
            run_one({8'(8'h10 + i), 8'(8'h80 + i), 16'h0}, 8'h41, 0, 0, 0, "nest");
        chk("nest_fault", fault, 64'd1);
        chk("nest_sp", sp, DEPTH);
        chk("nest_ip", ip, 64'h80 + DEPTH - 1);
        hold_check(4, "fault_hold");

        do_reset("rst1");
        run_one(32'h08000000, 8'h42, 0, 0, 0, "ret_empty");
        chk("ret_empty_fault", fault, 64'd1);
        hold_check(3, "ret_fault_hold");

        do_reset("rst2");
        run_one(32'h07000000, 8'h43, 0, 0, 0, "halt");
        chk("halt_flag", halted, 64'd1);
        hold_check(5, "halt_hold");

        do_reset("rst3");
        line_mem[0] = 32'h01201011;
        instr_mem[1] = 8'h00;
        stalls[0] = 6; stalls[1] = 0; stalls[2] = 0;
        k = 0;
        while (!ram_rd_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach_load1", ram_rd_en, 64'd1);
        @(negedge clk);
        chk("mid_still_busy", ram_busy, 64'd1);
        do_reset("rst_mid");
        run_one(32'h01201011, 8'h00, 0, 0, 0, "restart_add");
        chk("restart_ip1", ip, 64'd1);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
